// File: rtl/texture_pass_sequencer_if.sv
// Stream bundle for texture_pass_sequencer: fragment in (s), pass issue (t),
// pass result (r) and fragment out (m). The master modport is the sequencer's own view.
interface texture_pass_sequencer_if #(
   parameter int TMU_COUNT       = 2,
   parameter int USER_WIDTH      = 1,
   parameter int SUB_PIXEL_WIDTH = 8
);
   localparam int PIXEL_WIDTH   = 4 * SUB_PIXEL_WIDTH;
   localparam int TMU_IDX_WIDTH = (TMU_COUNT > 1) ? $clog2(TMU_COUNT) : 1;

   logic                      s_valid;
   logic                      s_ready;
   logic [USER_WIDTH-1:0]     s_user;
   logic [PIXEL_WIDTH-1:0]    s_primaryColor;
   logic [32*TMU_COUNT-1:0]   s_textureS;
   logic [32*TMU_COUNT-1:0]   s_textureT;
   logic [32*TMU_COUNT-1:0]   s_mipmapS;
   logic [32*TMU_COUNT-1:0]   s_mipmapT;

   logic                      t_valid;
   logic                      t_ready;
   logic [TMU_IDX_WIDTH-1:0]  t_tmu;
   logic [PIXEL_WIDTH-1:0]    t_primaryColor;
   logic [PIXEL_WIDTH-1:0]    t_previousColor;
   logic [31:0]               t_textureS;
   logic [31:0]               t_textureT;
   logic [31:0]               t_mipmapS;
   logic [31:0]               t_mipmapT;

   logic                      r_valid;
   logic                      r_ready;
   logic [PIXEL_WIDTH-1:0]    r_fragmentColor;

   logic                      m_valid;
   logic                      m_ready;
   logic [USER_WIDTH-1:0]     m_user;
   logic [PIXEL_WIDTH-1:0]    m_fragmentColor;

   modport master (
      input  s_valid, s_user, s_primaryColor, s_textureS, s_textureT, s_mipmapS, s_mipmapT,
      output s_ready,
      output t_valid, t_tmu, t_primaryColor, t_previousColor, t_textureS, t_textureT, t_mipmapS, t_mipmapT,
      input  t_ready,
      input  r_valid, r_fragmentColor,
      output r_ready,
      output m_valid, m_user, m_fragmentColor,
      input  m_ready
   );

   modport slave (
      output s_valid, s_user, s_primaryColor, s_textureS, s_textureT, s_mipmapS, s_mipmapT,
      input  s_ready,
      input  t_valid, t_tmu, t_primaryColor, t_previousColor, t_textureS, t_textureT, t_mipmapS, t_mipmapT,
      output t_ready,
      output r_valid, r_fragmentColor,
      input  r_ready,
      input  m_valid, m_user, m_fragmentColor,
      output m_ready
   );
endinterface

// File: rtl/texture_pass_sequencer.sv
// Multi-texturing front end: runs one pass per enabled texture unit through a shared
// texture core, chaining each pass result in as the next pass's previous colour.
module texture_pass_sequencer #(
   parameter int TMU_COUNT       = 2,
   parameter int USER_WIDTH      = 1,
   parameter int SUB_PIXEL_WIDTH = 8
) (
   input  logic                 aclk,
   input  logic                 resetn,
   input  logic [TMU_COUNT-1:0] confEnable,
   texture_pass_sequencer_if.master bus
);
   localparam int PIXEL_WIDTH   = 4 * SUB_PIXEL_WIDTH;
   localparam int TMU_IDX_WIDTH = (TMU_COUNT > 1) ? $clog2(TMU_COUNT) : 1;
   localparam int COORD_WIDTH   = 32 * TMU_COUNT;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   state_t                   state_r;
   logic [TMU_COUNT-1:0]     pend_r;
   logic [TMU_IDX_WIDTH-1:0] idx_r;
   logic [PIXEL_WIDTH-1:0]   prim_r;
   logic [PIXEL_WIDTH-1:0]   prev_r;
   logic [USER_WIDTH-1:0]    user_r;
   logic [COORD_WIDTH-1:0]   tex_s_r, tex_t_r, mip_s_r, mip_t_r;
   logic [31:0]              pass_tex_s_r, pass_tex_t_r, pass_mip_s_r, pass_mip_t_r;

   logic [TMU_COUNT-1:0]     cand_mask_s;
   logic [COORD_WIDTH-1:0]   cand_tex_s_s, cand_tex_t_s, cand_mip_s_s, cand_mip_t_s;
   logic [TMU_IDX_WIDTH-1:0] next_idx_s;
   logic [31:0]              next_tex_s_s, next_tex_t_s, next_mip_s_s, next_mip_t_s;

   function automatic logic [TMU_IDX_WIDTH-1:0] lowest_set(input logic [TMU_COUNT-1:0] mask);
      logic [TMU_IDX_WIDTH-1:0] res;
      res = '0;
      for (int i = TMU_COUNT - 1; i >= 0; i--) begin
         if (mask[i]) begin
            res = TMU_IDX_WIDTH'(i);
         end
      end
      return res;
   endfunction

   // Next pass selection: from the incoming fragment while idle, else from the stored one
   always_comb begin
      if (state_r == IDLE) begin
         cand_mask_s  = confEnable;
         cand_tex_s_s = bus.s_textureS;
         cand_tex_t_s = bus.s_textureT;
         cand_mip_s_s = bus.s_mipmapS;
         cand_mip_t_s = bus.s_mipmapT;
      end else begin
         cand_mask_s  = pend_r;
         cand_tex_s_s = tex_s_r;
         cand_tex_t_s = tex_t_r;
         cand_mip_s_s = mip_s_r;
         cand_mip_t_s = mip_t_r;
      end
      next_idx_s   = lowest_set(cand_mask_s);
      next_tex_s_s = cand_tex_s_s[{next_idx_s, 5'd0} +: 32];
      next_tex_t_s = cand_tex_t_s[{next_idx_s, 5'd0} +: 32];
      next_mip_s_s = cand_mip_s_s[{next_idx_s, 5'd0} +: 32];
      next_mip_t_s = cand_mip_t_s[{next_idx_s, 5'd0} +: 32];
   end

   // Pass sequencing FSM; pass payload is loaded on entry to ISSUE so it holds under stall
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         pend_r       <= '0;
         idx_r        <= '0;
         prim_r       <= '0;
         prev_r       <= '0;
         user_r       <= '0;
         tex_s_r      <= '0;
         tex_t_r      <= '0;
         mip_s_r      <= '0;
         mip_t_r      <= '0;
         pass_tex_s_r <= '0;
         pass_tex_t_r <= '0;
         pass_mip_s_r <= '0;
         pass_mip_t_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.s_valid) begin
                  pend_r  <= confEnable;
                  prim_r  <= bus.s_primaryColor;
                  prev_r  <= bus.s_primaryColor;
                  user_r  <= bus.s_user;
                  tex_s_r <= bus.s_textureS;
                  tex_t_r <= bus.s_textureT;
                  mip_s_r <= bus.s_mipmapS;
                  mip_t_r <= bus.s_mipmapT;
                  if (confEnable != '0) begin
                     state_r      <= ISSUE;
                     idx_r        <= next_idx_s;
                     pass_tex_s_r <= next_tex_s_s;
                     pass_tex_t_r <= next_tex_t_s;
                     pass_mip_s_r <= next_mip_s_s;
                     pass_mip_t_r <= next_mip_t_s;
                  end else begin
                     state_r <= OUTPUT;
                  end
               end
            end
            ISSUE: begin
               if (bus.t_ready) begin
                  pend_r[idx_r] <= 1'b0;
                  state_r       <= WAIT;
               end
            end
            WAIT: begin
               if (bus.r_valid) begin
                  prev_r <= bus.r_fragmentColor;
                  if (pend_r != '0) begin
                     state_r      <= ISSUE;
                     idx_r        <= next_idx_s;
                     pass_tex_s_r <= next_tex_s_s;
                     pass_tex_t_r <= next_tex_t_s;
                     pass_mip_s_r <= next_mip_s_s;
                     pass_mip_t_r <= next_mip_t_s;
                  end else begin
                     state_r <= OUTPUT;
                  end
               end
            end
            OUTPUT: begin
               if (bus.m_ready) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready         = (state_r == IDLE);
   assign bus.t_valid         = (state_r == ISSUE);
   assign bus.r_ready         = (state_r == WAIT);
   assign bus.m_valid         = (state_r == OUTPUT);
   assign bus.t_tmu           = idx_r;
   assign bus.t_primaryColor  = prim_r;
   assign bus.t_previousColor = prev_r;
   assign bus.t_textureS      = pass_tex_s_r;
   assign bus.t_textureT      = pass_tex_t_r;
   assign bus.t_mipmapS       = pass_mip_s_r;
   assign bus.t_mipmapT       = pass_mip_t_r;
   assign bus.m_user          = user_r;
   assign bus.m_fragmentColor = prev_r;
endmodule

// File: tb/tb_texture_pass_sequencer.sv
// Randomised self-checking bench for texture_pass_sequencer with a queue-based pass model
// and a bench-side texture core of configurable latency.
module tb_texture_pass_sequencer;
   logic       aclk;
   logic       resetn;
   logic [1:0] conf_enable;

   texture_pass_sequencer_if #(.TMU_COUNT(2), .USER_WIDTH(1), .SUB_PIXEL_WIDTH(8)) bus ();

   texture_pass_sequencer #(.TMU_COUNT(2), .USER_WIDTH(1), .SUB_PIXEL_WIDTH(8)) dut (
      .aclk       (aclk),
      .resetn     (resetn),
      .confEnable (conf_enable),
      .bus        (bus)
   );

   typedef struct {
      logic [0:0]  user;
      logic [31:0] prim;
      logic [63:0] ts, tt, ms, mt;
      logic [1:0]  en;
   } frag_t;
   typedef struct {
      logic [0:0]  tmu;
      logic [31:0] prim, prev, ts, tt, ms, mt;
   } pass_t;
   typedef struct {
      logic [0:0]  user;
      logic [31:0] color;
   } out_t;

   frag_t src_q[$];
   pass_t exp_t[$];
   out_t  exp_m[$];
   pass_t t_log[$];
   out_t  m_log[$];

   int n_tests = 0, n_fail = 0;
   int cyc = 0, n_out = 0, n_mvalid = 0, outstanding = 0;
   int accept_cyc = 0, first_t_cyc = -1, first_m_cyc = -1, t_valid_cnt = 0;
   bit in_flight = 0, rand_mode = 0, core_mode = 0;
   int core_lat = 0, t_stall = 0, m_stall = 0;
   bit s_hs_f = 0, t_hs_f = 0, r_hs_f = 0, m_hs_f = 0;
   bit core_busy = 0;
   int core_cnt = 0;
   logic [31:0] core_res, core_val;
   bit t_held = 0, m_held = 0;
   logic [255:0] t_snap, m_snap;

   function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Texture core behaviour: a fixed function of the pass operands
   function automatic logic [31:0] core_fn(input pass_t p);
      if (core_mode == 1'b0) return p.prev ^ 32'hFFFF_FFFF;
      return {p.prev[23:0], p.prev[31:24]} ^ p.ts ^ {p.tt[30:0], 1'b0} ^ p.ms ^ ~p.mt ^ p.prim
             ^ ((p.tmu == 1'b1) ? 32'h5A5A_0000 : 32'h0000_A5A5);
   endfunction

   // Expands an accepted fragment into its expected passes and final colour
   function automatic void model_accept(input frag_t f);
      pass_t p;
      out_t o;
      logic [31:0] prev;
      prev = f.prim;
      for (int i = 0; i < 2; i++) begin
         if (f.en[i]) begin
            p.tmu  = 1'(i);
            p.prim = f.prim;
            p.prev = prev;
            p.ts   = f.ts[32*i +: 32];
            p.tt   = f.tt[32*i +: 32];
            p.ms   = f.ms[32*i +: 32];
            p.mt   = f.mt[32*i +: 32];
            exp_t.push_back(p);
            prev = core_fn(p);
         end
      end
      o.user  = f.user;
      o.color = prev;
      exp_m.push_back(o);
   endfunction

   function automatic void monitor_cycle();
      pass_t a, e;
      out_t mo, me;
      frag_t f;
      logic [255:0] t_now, m_now;
      cyc++;
      if (!resetn) begin
         exp_t.delete(); exp_m.delete();
         outstanding = 0; in_flight = 0; t_held = 0; m_held = 0;
         return;
      end
      t_now = {bus.t_tmu, bus.t_primaryColor, bus.t_previousColor, bus.t_textureS,
               bus.t_textureT, bus.t_mipmapS, bus.t_mipmapT};
      m_now = {bus.m_user, bus.m_fragmentColor};
      check("s_ready_when_free", bus.s_ready, !in_flight);
      if (bus.t_valid) check("t_valid_no_outstanding", outstanding, 0);
      if (bus.r_ready) check("r_ready_one_outstanding", outstanding, 1);
      if (t_held) begin
         check("t_valid_hold", bus.t_valid, 1'b1);
         check("t_payload_hold", t_now, t_snap);
      end
      if (m_held) begin
         check("m_valid_hold", bus.m_valid, 1'b1);
         check("m_payload_hold", m_now, m_snap);
      end
      if (bus.t_valid) begin
         t_valid_cnt++;
         if (first_t_cyc < 0) first_t_cyc = cyc;
      end
      if (bus.m_valid) begin
         n_mvalid++;
         if (first_m_cyc < 0) first_m_cyc = cyc;
      end
      if (bus.s_valid && bus.s_ready) begin
         f.user = bus.s_user; f.prim = bus.s_primaryColor; f.en = conf_enable;
         f.ts = bus.s_textureS; f.tt = bus.s_textureT; f.ms = bus.s_mipmapS; f.mt = bus.s_mipmapT;
         model_accept(f);
         in_flight = 1; accept_cyc = cyc; first_t_cyc = -1; first_m_cyc = -1; t_valid_cnt = 0;
         s_hs_f = 1;
      end
      if (bus.t_valid && bus.t_ready) begin
         a.tmu = bus.t_tmu; a.prim = bus.t_primaryColor; a.prev = bus.t_previousColor;
         a.ts = bus.t_textureS; a.tt = bus.t_textureT; a.ms = bus.t_mipmapS; a.mt = bus.t_mipmapT;
         check("t_pass_expected", exp_t.size() != 0, 1'b1);
         if (exp_t.size() != 0) begin
            e = exp_t.pop_front();
            check("t_tmu", a.tmu, e.tmu);
            check("t_primaryColor", a.prim, e.prim);
            check("t_previousColor", a.prev, e.prev);
            check("t_coords", {a.ts, a.tt, a.ms, a.mt}, {e.ts, e.tt, e.ms, e.mt});
         end
         t_log.push_back(a);
         outstanding++;
         core_res = core_fn(a);
         t_hs_f = 1;
      end
      if (bus.r_valid && bus.r_ready) begin
         outstanding--;
         r_hs_f = 1;
      end
      if (bus.m_valid && bus.m_ready) begin
         mo.user = bus.m_user; mo.color = bus.m_fragmentColor;
         check("m_fragment_expected", exp_m.size() != 0, 1'b1);
         if (exp_m.size() != 0) begin
            me = exp_m.pop_front();
            check("m_user", mo.user, me.user);
            check("m_fragmentColor", mo.color, me.color);
         end
         m_log.push_back(mo);
         in_flight = 0;
         n_out++;
         m_hs_f = 1;
      end
      t_held = bus.t_valid && !bus.t_ready;
      m_held = bus.m_valid && !bus.m_ready;
      t_snap = t_now;
      m_snap = m_now;
   endfunction

   task automatic drive_cycle();
      if (!resetn) begin
         bus.s_valid = 1'b0; bus.r_valid = 1'b0; core_busy = 0;
         s_hs_f = 0; t_hs_f = 0; r_hs_f = 0; m_hs_f = 0;
         return;
      end
      if (s_hs_f) begin
         src_q.delete(0);
         bus.s_valid = 1'b0;
      end
      if (!bus.s_valid) begin
         if (src_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
            bus.s_valid = 1'b1;
            bus.s_user = src_q[0].user; bus.s_primaryColor = src_q[0].prim;
            bus.s_textureS = src_q[0].ts; bus.s_textureT = src_q[0].tt;
            bus.s_mipmapS = src_q[0].ms; bus.s_mipmapT = src_q[0].mt;
         end else begin
            bus.s_primaryColor = $urandom;
            bus.s_textureS = {$urandom, $urandom};
         end
      end
      conf_enable = rand_mode ? 2'($urandom) : ((src_q.size() > 0) ? src_q[0].en : 2'b00);
      if (r_hs_f) begin
         bus.r_valid = 1'b0;
         core_busy = 0;
      end
      if (t_hs_f) begin
         core_busy = 1;
         core_cnt = (core_lat < 0) ? $urandom_range(0, 7) : core_lat;
         core_val = core_res;
      end
      if (core_busy && !bus.r_valid) begin
         if (core_cnt == 0) begin
            bus.r_valid = 1'b1;
            bus.r_fragmentColor = core_val;
         end else begin
            core_cnt--;
         end
      end
      bus.t_ready = rand_mode ? 1'($urandom) : 1'b1;
      if (bus.t_valid && t_stall > 0) begin
         bus.t_ready = 1'b0;
         t_stall--;
      end
      bus.m_ready = rand_mode ? 1'($urandom) : 1'b1;
      if (bus.m_valid && m_stall > 0) begin
         bus.m_ready = 1'b0;
         m_stall--;
      end
      s_hs_f = 0; t_hs_f = 0; r_hs_f = 0; m_hs_f = 0;
   endtask

   task automatic wait_out(input int target, input int budget);
      int k;
      k = 0;
      while (n_out < target && k < budget) begin
         @(negedge aclk);
         k++;
      end
      check("wait_out_timeout", n_out >= target, 1'b1);
      repeat (3) @(negedge aclk);
   endtask

   function automatic frag_t mk_frag(input logic [31:0] prim, input logic [1:0] en, input logic [0:0] user);
      frag_t f;
      f.prim = prim; f.en = en; f.user = user;
      f.ts = {$urandom, $urandom}; f.tt = {$urandom, $urandom};
      f.ms = {$urandom, $urandom}; f.mt = {$urandom, $urandom};
      return f;
   endfunction

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      forever begin
         @(negedge aclk);
         monitor_cycle();
         @(posedge aclk);
         #1;
         drive_cycle();
      end
   end

   initial begin
      frag_t f;
      int base, mv0, k;
      bus.s_valid = 1'b0; bus.s_user = '0; bus.s_primaryColor = '0;
      bus.s_textureS = '0; bus.s_textureT = '0; bus.s_mipmapS = '0; bus.s_mipmapT = '0;
      bus.t_ready = 1'b1; bus.r_valid = 1'b0; bus.r_fragmentColor = '0; bus.m_ready = 1'b1;
      conf_enable = 2'b00;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(posedge aclk);
      #2;
      check("rst_s_ready", bus.s_ready, 1'b1);
      check("rst_t_valid", bus.t_valid, 1'b0);
      check("rst_r_ready", bus.r_ready, 1'b0);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_t_tmu", bus.t_tmu, 1'b0);
      check("rst_t_previousColor", bus.t_previousColor, 32'h0);
      check("rst_m_fragmentColor", bus.m_fragmentColor, 32'h0);
      check("rst_m_user", bus.m_user, 1'b0);
      @(posedge aclk);
      #3 resetn = 1'b1;

      // Two chained passes through an inverting core, result 3 cycles after issue
      rand_mode = 0; core_mode = 0; core_lat = 2;
      t_log.delete(); m_log.delete();
      src_q.push_back(mk_frag(32'h1122_3344, 2'b11, 1'b0));
      wait_out(1, 200);
      check("a_pass_count", t_log.size(), 2);
      if (t_log.size() == 2) begin
         check("a_pass0_tmu", t_log[0].tmu, 1'b0);
         check("a_pass0_prev", t_log[0].prev, 32'h1122_3344);
         check("a_pass1_tmu", t_log[1].tmu, 1'b1);
         check("a_pass1_prev", t_log[1].prev, 32'hEEDD_CCBB);
      end
      check("a_color", m_log[0].color, 32'h1122_3344);
      check("a_first_t_latency", first_t_cyc - accept_cyc, 1);
      check("a_m_latency", first_m_cyc - accept_cyc, 9);

      // Only unit 1 enabled, zero-latency core
      core_lat = 0;
      t_log.delete(); m_log.delete();
      f = mk_frag(32'h1234_5678, 2'b10, 1'b0);
      f.ts = 64'h0002_0000_0001_0000;
      src_q.push_back(f);
      wait_out(2, 200);
      check("b_pass_count", t_log.size(), 1);
      check("b_pass_tmu", t_log[0].tmu, 1'b1);
      check("b_pass_textureS", t_log[0].ts, 32'h0002_0000);
      check("b_color", m_log[0].color, 32'hEDCB_A987);

      // No unit enabled: straight to output
      t_log.delete(); m_log.delete();
      src_q.push_back(mk_frag(32'hAABB_CCDD, 2'b00, 1'b1));
      wait_out(3, 200);
      check("c_color", m_log[0].color, 32'hAABB_CCDD);
      check("c_user", m_log[0].user, 1'b1);
      check("c_m_latency", first_m_cyc - accept_cyc, 1);
      check("c_no_t_valid", t_valid_cnt, 0);

      // Backpressure on both the issue and the output streams
      core_mode = 1; core_lat = 1; t_stall = 5; m_stall = 4;
      src_q.push_back(mk_frag($urandom, 2'b11, 1'b1));
      wait_out(4, 300);
      check("d_t_stall_used", t_stall, 0);
      check("d_m_stall_used", m_stall, 0);

      // Reset while waiting for a result discards the fragment
      core_lat = 6;
      src_q.push_back(mk_frag($urandom, 2'b11, 1'b0));
      k = 0;
      while (!bus.r_ready && k < 100) begin
         @(negedge aclk);
         k++;
      end
      check("e_reached_wait", bus.r_ready, 1'b1);
      base = n_out;
      mv0 = n_mvalid;
      #2 resetn = 1'b0;
      #1;
      check("e_rst_s_ready", bus.s_ready, 1'b1);
      check("e_rst_t_valid", bus.t_valid, 1'b0);
      check("e_rst_r_ready", bus.r_ready, 1'b0);
      check("e_rst_m_valid", bus.m_valid, 1'b0);
      repeat (2) @(posedge aclk);
      #3 resetn = 1'b1;
      repeat (20) @(negedge aclk);
      check("e_no_output", n_out, base);
      check("e_no_m_valid", n_mvalid, mv0);

      // Random traffic
      rand_mode = 1; core_mode = 1; core_lat = -1;
      base = n_out;
      for (int i = 0; i < 1000; i++) begin
         src_q.push_back(mk_frag($urandom, 2'b00, 1'($urandom)));
      end
      wait_out(base + 1000, 80000);
      check("end_no_pending_pass", exp_t.size(), 0);
      check("end_no_pending_out", exp_m.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/texture_pass_sequencer.md
# texture_pass_sequencer

Multi-texturing front end that places a parametrised number of texture units (TMU_COUNT) in front of a single shared texture mapping core, which samples, filters and applies the texture environment. It accepts one fragment carrying TMU_COUNT coordinate sets and issues one pass per enabled unit to the core, in ascending unit order. The colour returned by each pass is fed back as the PREVIOUS colour of the next pass. It sits between the attribute interpolator and the per-fragment operations, so fragment traffic is unchanged on both sides.

## Interface
- TMU_COUNT, 2: number of texture units; legal range 1..8.
- USER_WIDTH, 1: sideband width, passed through unmodified.
- SUB_PIXEL_WIDTH, 8: bits per colour channel; PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH (localparam).
- TMU_IDX_WIDTH (localparam): max(1, clog2(TMU_COUNT)).

Ports:
- aclk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- confEnable  in  TMU_COUNT  per-unit enable; bit i set means pass i is executed. Sampled on fragment accept.
- s_valid / s_ready  in/out  1  fragment input handshake.
- s_user  in  USER_WIDTH  sideband.
- s_primaryColor  in  PIXEL_WIDTH  PRIMARY_COLOR.
- s_textureS, s_textureT, s_mipmapS, s_mipmapT  in  32*TMU_COUNT  each; unit i occupies bits [32*i +: 32].
- t_valid / t_ready  out/in  1  pass issue handshake to the core.
- t_tmu  out  TMU_IDX_WIDTH  unit index of the pass (selects that unit's configuration and texture memory).
- t_primaryColor, t_previousColor  out  PIXEL_WIDTH  colour operands of the pass.
- t_textureS, t_textureT, t_mipmapS, t_mipmapT  out  32  selected unit's coordinates.
- r_valid / r_ready  in/out  1  pass result handshake from the core.
- r_fragmentColor  in  PIXEL_WIDTH  pass result.
- m_valid / m_ready  out/in  1  fragment output handshake.
- m_user  out  USER_WIDTH  sideband.
- m_fragmentColor  out  PIXEL_WIDTH  final colour.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, OUTPUT. Reset state is IDLE.
- IDLE: s_ready=1. On s_valid&s_ready, register the fragment and latch confEnable into pending mask P. Set prev = s_primaryColor (unit 0's PREVIOUS is the primary colour).
  - P≠0: go to ISSUE with idx = lowest set bit of P.
  - P=0: go to OUTPUT with colour = primary colour.
- ISSUE: t_valid=1; all t_* outputs are registered and stable while t_valid && !t_ready. On handshake, clear P[idx] and go to WAIT.
- WAIT: r_ready=1. On r handshake, prev = r_fragmentColor.
  - P≠0: go to ISSUE with idx = next lowest set bit of P.
  - P=0: go to OUTPUT.
- OUTPUT: m_valid=1, m_fragmentColor=prev, m_user = registered s_user. On m handshake, go to IDLE.
- r_ready=0 outside WAIT. A result that arrives early is held by the core and is never dropped.
- Disabled units are skipped with zero cycles spent; no t transfer occurs for them.
- confEnable changes after accept do not affect the in-flight fragment.
- Exactly one fragment is in flight; the core may have any latency, including 0 cycles (r_valid in the cycle after t handshake).
- Reset mid-operation: the in-flight fragment is discarded. Outputs return to reset values asynchronously.

## Timing
- Reset values: s_ready=1, t_valid=0, r_ready=0, m_valid=0. All data outputs, t_tmu and internal registers are 0.
- Accept at cycle 0 → t_valid at cycle 1.
- r handshake at cycle n → next t_valid, or m_valid, at cycle n+1.
- No enabled unit: accept at cycle 0 → m_valid at cycle 1.
- Per-fragment latency = 2 + Σ over enabled passes of (t stall + core latency + 1) cycles.
- m handshake at cycle k → s_ready=1 at cycle k+1.
- No combinational path from any input to any output. All valid and ready outputs are decoded directly from state registers.
- AXI-stream rules apply: no valid may depend on a ready; payloads hold while valid && !ready.

## Test plan
- Reset: assert resetn=0 mid-WAIT → s_ready=1, t_valid=r_ready=m_valid=0 immediately. The fragment is never emitted.
- TMU_COUNT=2, confEnable=2'b11, primary=0x11223344, core returns prev^0xFFFFFFFF after 3 cycles:
  - pass0 has t_tmu=0, t_previousColor=0x11223344.
  - pass1 has t_tmu=1, t_previousColor=0xEEDDCCBB.
  - m_fragmentColor=0x11223344. Total latency 2+4+4=10 cycles.
- confEnable=2'b10, textureS={0x00020000,0x00010000}: exactly one pass, with t_tmu=1 and t_textureS=0x00020000. m_fragmentColor equals the core result.
- confEnable=0, primary=0xAABBCCDD, user=1: m_valid at cycle 1 with colour 0xAABBCCDD and m_user=1. No t_valid ever asserted.
- Backpressure: hold t_ready=0 for 5 cycles, then m_ready=0 for 4 cycles → t_* and m_* stay stable throughout, s_ready stays 0, and no data is lost.
- Random streams of 1000 fragments with random valid/ready, random confEnable and core latency 0..7 → outputs match a reference model in order.
